muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Multi-cycle sequencer for the HI/LO half of the execute stage. It accepts MULT/MULTU/DIV/DIVU from the ALU op decode and runs a 32-iteration shift-add multiply or restoring divide, then commits the result to architectural HI/LO. It serves MFHI/MFLO from those registers and raises `stall` to freeze the pipeline while a younger HI/LO consumer or second mult/div meets an operation in flight.

## Interface
- `WIDTH`, 32, operand width; HI/LO are each WIDTH bits, the product is 2*WIDTH.
- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  execute-stage instruction valid this cycle.
- `ALUOp`  in  6  decoded op, shared ALU encoding; only MULT, MULTU, DIV, DIVU, MFHI and MFLO are acted on.
- `rsData`  in  WIDTH  multiplicand / dividend.
- `rtData`  in  WIDTH  multiplier / divisor.
- `flush`  in  1  abort in-flight op; HI/LO unchanged.
- `stall`  out  1  combinational; upstream holds `start`/`ALUOp`/operands while high.
- `busy`  out  1  operation in flight (RUN or FIX).
- `done`  out  1  one-cycle pulse; HI/LO updated.
- `hiOut`  out  WIDTH  architectural HI register.
- `loOut`  out  WIDTH  architectural LO register.
- `dataOut`  out  WIDTH  combinational; HI for MFHI, LO for MFLO, else 0.

## Operation
- States: IDLE, RUN, FIX.
- **IDLE:**
  - `start` with a mult/div op → latch magnitudes (abs for signed ops, raw for unsigned), result-sign flags and op kind; clear the iteration count; go to RUN.
  - Other ops are ignored.
- **RUN:**
  - One iteration per cycle, count 0..31.
  - Multiply: add the multiplicand to the upper accumulator if the LSB is set, then shift right.
  - Divide: shift the remainder/quotient left and conditionally subtract.
  - After iteration 31, go to FIX.
- **FIX:**
  - Apply sign fixup and write HI/LO; go to IDLE.
  - Multiply: 64-bit negate if the operand signs differ; HI = upper half, LO = lower half.
  - Divide: LO = quotient, negated if the operand signs differ; HI = remainder, carrying the sign of the dividend.
- **Divide by zero** (DIV or DIVU): HI = rsData as issued, LO = 32'hFFFF_FFFF. No sign fixup, no trap.
- **DIV of 32'h8000_0000 by 32'hFFFF_FFFF:** LO = 32'h8000_0000, HI = 0. This falls out of modulo-2^32 magnitude arithmetic.
- **`stall`** = `start` && `busy` && ALUOp ∈ {MULT, MULTU, DIV, DIVU, MFHI, MFLO}.
  - Other ops never stall.
  - An op that is stalled is not accepted.
- **MFHI/MFLO** with `busy` = 0 read `dataOut` the same cycle. No state change.
- **`flush`:**
  - In RUN or FIX, `flush` returns the block to IDLE at the next edge and leaves HI/LO untouched; `done` stays low.
  - `flush` in IDLE is a no-op.
  - `flush` has priority over acceptance of a new `start` in the same cycle; the op is not accepted.
- **Reset:** asynchronously forces IDLE with HI = LO = 0, `busy` = `done` = 0 and the datapath registers cleared. This includes reset asserted mid-operation.

## Timing
- Accept edge E0 → RUN for edges E1..E32 → HI/LO written at E33.
- `done` is high for the single cycle after E33; `busy` is high from E0 to E33.
- Latency is 33 cycles. A new op can be accepted at E33+1, i.e. in the `done` cycle.
- During the `done` cycle, MFHI/MFLO see the new values and do not stall.
- `hiOut`/`loOut` are registered and change only at a FIX edge or on reset.
- Operands are sampled only at E0; later input changes have no effect.

## Structure
- Shared package `alu_pkg` holds the 6-bit ALUOp encodings:
  - MULT = 6'b000101, MULTU = 6'b000110, DIV = 6'b000111, DIVU = 6'b001000, MFHI = 6'b001001, MFLO = 6'b001010.
- The ALU and the decoder import the same constants from `alu_pkg`.
- The state enum (IDLE/RUN/FIX) stays local to this module.
- One natural sub-module, `muldiv_iter`: a purely combinational single-step datapath (add/shift or subtract/shift) taking accumulator, operand and mode. The controller owns the state, the counter and the sign fixup.

## Test plan
- **Signed multiply:** MULT rs = 32'hFFFF_FFFD (-3), rt = 5 → `done` one cycle after E33; HI = 32'hFFFF_FFFF, LO = 32'hFFFF_FFF1.
- **Unsigned multiply:** MULTU rs = rt = 32'hFFFF_FFFF → HI = 32'hFFFF_FFFE, LO = 32'h0000_0001.
- **Signed divide:** DIV rs = 32'hFFFF_FFF9 (-7), rt = 2 → LO = 32'hFFFF_FFFD, HI = 32'hFFFF_FFFF.
- **Divide by zero and overflow:**
  - DIVU rs = 7, rt = 0 → HI = 7, LO = 32'hFFFF_FFFF.
  - DIV 32'h8000_0000 / 32'hFFFF_FFFF → LO = 32'h8000_0000, HI = 0.
- **Stall:**
  - MFHI presented 5 cycles after accept → `stall` = 1 for every cycle through E33, drops in the `done` cycle, and `dataOut` = new HI.
  - An ADD during `busy` → `stall` = 0.
- **Abort:**
  - `flush` at E10 → IDLE next edge, HI/LO keep prior values, no `done`.
  - `reset_n` low at E20 → HI = LO = 0 and `busy` = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU op encodings and op-class helpers for the execute stage.
// Pure declarations; no logic, no latency.
// No flow control; consumers decide how to act on each op class.
package alu_pkg;

  typedef logic [5:0] aluop_t;

  localparam aluop_t MULT  = 6'b000101;
  localparam aluop_t MULTU = 6'b000110;
  localparam aluop_t DIV   = 6'b000111;
  localparam aluop_t DIVU  = 6'b001000;
  localparam aluop_t MFHI  = 6'b001001;
  localparam aluop_t MFLO  = 6'b001010;

  // Ops that launch a 32-iteration multi-cycle operation.
  function automatic logic is_muldiv(input aluop_t op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

  // Ops that touch HI/LO and therefore must wait for an op in flight.
  function automatic logic is_hilo(input aluop_t op);
    return is_muldiv(op) || (op == MFHI) || (op == MFLO);
  endfunction

  // Signed variants take magnitudes and need a sign fixup at the end.
  function automatic logic is_signed_op(input aluop_t op);
    return (op == MULT) || (op == DIV);
  endfunction

  function automatic logic is_div_op(input aluop_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Execute-stage <-> HI/LO sequencer bundle: issue, operands, flush, status, results.
// Wires only; no latency.
// stall is the only backpressure: issuer holds start/ALUOp/operands while it is high.
interface muldiv_ctrl_if #(parameter int WIDTH = 32);

  logic             start;
  logic [5:0]       ALUOp;
  logic [WIDTH-1:0] rsData;
  logic [WIDTH-1:0] rtData;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hiOut;
  logic [WIDTH-1:0] loOut;
  logic [WIDTH-1:0] dataOut;

  modport master (
    output start, ALUOp, rsData, rtData, flush,
    input  stall, busy, done, hiOut, loOut, dataOut
  );

  modport slave (
    input  start, ALUOp, rsData, rtData, flush,
    output stall, busy, done, hiOut, loOut, dataOut
  );

endinterface

// File: rtl/muldiv_iter.sv
// One step of shift-add multiply or restoring divide on a 2*WIDTH accumulator.
// Purely combinational, zero latency.
// No flow control; the controller decides when a step is registered.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;

  // Multiply: {upper, lower}, add multiplicand to upper when lower LSB is set, shift right
  // with the add carry entering at the top. Divide: {remainder, quotient}, shift left and
  // keep the subtraction only when the shifted remainder covers the divisor.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    mul_next = acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

    trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = trial[WIDTH-1:0] - operand;
    if (trial >= {1'b0, operand})
      div_next = {diff, acc[WIDTH-2:0], 1'b1};
    else
      div_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

    acc_next = is_div ? div_next : mul_next;
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: MULT/MULTU/DIV/DIVU over 32 iterations, MFHI/MFLO readout.
// Latency 33 cycles accept-to-commit; done pulses the cycle after the commit edge.
// stall (combinational) holds HI/LO consumers and further mult/divs while busy; flush aborts.
module muldiv_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  muldiv_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      count;
  logic               op_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;
  logic [WIDTH-1:0]   rs_raw;
  logic [WIDTH-1:0]   operand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic               accept;
  logic               sgn;
  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .acc      (acc),
    .operand  (operand),
    .is_div   (op_div),
    .acc_next (acc_next)
  );

  // Issue decode: magnitudes are taken modulo 2^WIDTH, so the most negative value maps to itself,
  // which is what makes MIN / -1 come out as MIN with a zero remainder.
  always_comb begin
    accept = (state == S_IDLE) && bus.start && is_muldiv(bus.ALUOp) && !bus.flush;
    sgn    = is_signed_op(bus.ALUOp);
    rs_neg = sgn && bus.rsData[WIDTH-1];
    rt_neg = sgn && bus.rtData[WIDTH-1];
    rs_mag = rs_neg ? -bus.rsData : bus.rsData;
    rt_mag = rt_neg ? -bus.rtData : bus.rtData;
  end

  // Final sign fixup: product negated as a whole; quotient follows the sign product, remainder
  // follows the dividend. Divide by zero bypasses fixup and reports the raw dividend in HI.
  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (!op_div) begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end else if (div_zero) begin
      fix_hi = rs_raw;
      fix_lo = '1;
    end else begin
      fix_hi = rem_fix;
      fix_lo = quo_fix;
    end
  end

  // Sequencer: latch operands on accept, iterate in RUN, commit in FIX; flush abandons the op.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      count    <= '0;
      op_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      rs_raw   <= '0;
      operand  <= '0;
      acc      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_div   <= is_div_op(bus.ALUOp);
            neg_res  <= rs_neg ^ rt_neg;
            neg_rem  <= rs_neg;
            div_zero <= is_div_op(bus.ALUOp) && (bus.rtData == '0);
            rs_raw   <= bus.rsData;
            count    <= '0;
            if (is_div_op(bus.ALUOp)) begin
              operand <= rt_mag;
              acc     <= {{WIDTH{1'b0}}, rs_mag};
            end else begin
              operand <= rs_mag;
              acc     <= {{WIDTH{1'b0}}, rt_mag};
            end
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.flush) begin
            state <= S_IDLE;
          end else begin
            acc   <= acc_next;
            count <= count + CW'(1);
            if (count == LAST)
              state <= S_FIX;
          end
        end
        S_FIX: begin
          if (!bus.flush) begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status and readout; stall only ever asserts against HI/LO ops while an op is in flight.
  always_comb begin
    bus.busy    = (state != S_IDLE);
    bus.done    = done_q;
    bus.hiOut   = hi_q;
    bus.loOut   = lo_q;
    bus.stall   = bus.start && (state != S_IDLE) && is_hilo(bus.ALUOp);
    if (bus.ALUOp == MFHI)
      bus.dataOut = hi_q;
    else if (bus.ALUOp == MFLO)
      bus.dataOut = lo_q;
    else
      bus.dataOut = '0;
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a cycle-level reference model and literal expectations.
// Inputs change 1 time unit after each rising edge; outputs are compared on the falling edge.
// The model computes results with native 64-bit arithmetic and tracks timing as a countdown.
module tb_muldiv_ctrl;
  import alu_pkg::*;

  localparam logic [5:0] OP_ADD = 6'b100000;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  muldiv_ctrl_if #(.WIDTH(32)) bus ();

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_rem;   // cycles until commit; 0 means idle
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_done;

  function automatic logic [63:0] model_result(input logic [5:0] op, input logic [31:0] rs,
                                               input logic [31:0] rt);
    longint a, b, q, r;
    logic [63:0] res;
    res = '0;
    a = longint'($signed(rs));
    b = longint'($signed(rt));
    case (op)
      MULT:  res = 64'(a * b);
      MULTU: res = {32'b0, rs} * {32'b0, rt};
      DIV: begin
        if (rt == 32'd0) res = {rs, 32'hFFFF_FFFF};
        else begin
          q = a / b;
          r = a % b;
          res = {r[31:0], q[31:0]};
        end
      end
      DIVU: begin
        if (rt == 32'd0) res = {rs, 32'hFFFF_FFFF};
        else res = {rs % rt, rs / rt};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_rem = 0; m_hi = '0; m_lo = '0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        if (bus.flush) m_rem = 0;
        else begin
          m_rem--;
          if (m_rem == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
          end
        end
      end else if (bus.start && !bus.flush && (bus.ALUOp inside {MULT, MULTU, DIV, DIVU})) begin
        {p_hi, p_lo} = model_result(bus.ALUOp, bus.rsData, bus.rtData);
        m_rem = 33;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    logic        exp_stall;
    logic [31:0] exp_data;
    exp_stall = bus.start && (m_rem > 0) && (bus.ALUOp inside {MULT, MULTU, DIV, DIVU, MFHI, MFLO});
    exp_data  = (bus.ALUOp == MFHI) ? m_hi : (bus.ALUOp == MFLO) ? m_lo : 32'd0;
    check("cyc busy",    bus.busy,    m_rem > 0);
    check("cyc done",    bus.done,    m_done);
    check("cyc hiOut",   bus.hiOut,   m_hi);
    check("cyc loOut",   bus.loOut,   m_lo);
    check("cyc stall",   bus.stall,   exp_stall);
    check("cyc dataOut", bus.dataOut, exp_data);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic s, input logic [5:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic f);
    bus.start = s; bus.ALUOp = op; bus.rsData = rs; bus.rtData = rt; bus.flush = f;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    lat = 0;
    drive(1'b1, op, rs, rt, 1'b0);
    tick();                                        // accept edge
    drive(1'b0, 6'd0, $urandom, $urandom, 1'b0);   // later operand changes must not matter
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      tick();
      if (bus.done) lat = i;
    end
    check({name, " latency"}, lat, 33);
    check({name, " hi"}, bus.hiOut, exp_hi);
    check({name, " lo"}, bus.loOut, exp_lo);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int stall_cycles;
    int dones;
    logic seen;

    drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
    #1;
    check("reset hi",   bus.hiOut, 0);
    check("reset lo",   bus.loOut, 0);
    check("reset busy", bus.busy,  0);
    check("reset done", bus.done,  0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    run_op("mult",  MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div",   DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu0", DIVU,  32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF);
    run_op("divov", DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000);
    run_op("div0s", DIV,   32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFF0, 32'hFFFF_FFFF);

    // MFLO while idle reads LO the same cycle.
    drive(1'b1, MFLO, 32'd0, 32'd0, 1'b0);
    #2;
    check("idle mflo data",  bus.dataOut, 32'hFFFF_FFFF);
    check("idle mflo stall", bus.stall,   0);
    tick();

    // Stall: ADD during busy never stalls; MFHI from 5 cycles after accept stalls until done.
    drive(1'b1, MULT, 32'h0001_0001, 32'h0003_0000, 1'b0);
    tick();
    drive(1'b1, OP_ADD, 32'd1, 32'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #2;
      check("add stall", bus.stall, 0);
      tick();
    end
    drive(1'b1, MFHI, 32'd0, 32'd0, 1'b0);
    stall_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      #2;
      if (bus.done) begin
        seen = 1'b1;
        check("mfhi stall at done", bus.stall,   0);
        check("mfhi data at done",  bus.dataOut, 32'd3);
      end else begin
        if (bus.stall) stall_cycles++;
        tick();
      end
    end
    check("mfhi done seen",   seen,         1);
    check("mfhi stall count", stall_cycles, 28);
    tick();
    drive(1'b1, MFLO, 32'd0, 32'd0, 1'b0);
    #2;
    check("mflo after mult", bus.dataOut, 32'h0003_0000);
    tick();

    // Flush at E10 abandons the op and leaves HI/LO alone.
    drive(1'b1, MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    tick();
    drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush busy", bus.busy, 0);
    dones = 0;
    for (int i = 0; i < 35; i++) begin
      tick();
      if (bus.done) dones++;
    end
    check("flush no done", dones, 0);
    check("flush hi kept", bus.hiOut, 32'd3);
    check("flush lo kept", bus.loOut, 32'h0003_0000);

    // Flush in the same cycle as a start blocks acceptance.
    drive(1'b1, MULT, 32'd2, 32'd3, 1'b1);
    tick();
    drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
    check("flush+start busy", bus.busy, 0);
    tick();

    // Reset asserted at E20 clears state without a clock edge.
    drive(1'b1, DIVU, 32'd100, 32'd7, 1'b0);
    tick();
    drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("async rst hi",   bus.hiOut, 0);
    check("async rst lo",   bus.loOut, 0);
    check("async rst busy", bus.busy,  0);
    tick();
    reset_n = 1'b1;
    tick();

    run_op("divu", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
